// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 4-bit bus receiver.
// Shadows the visible 16x2 DDRAM from observed writes.
module lcd_bus_monitor #(
  parameter int unsigned NIBBLE_TIMEOUT = 1_000_000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         LCD_E,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic [3:0]   LCD_D,
  output logic [0:127] row_A,
  output logic [0:127] row_B,
  output logic         byte_valid,
  output logic         byte_rs,
  output logic [7:0]   byte_data,
  output logic         mode_4bit,
  output logic [6:0]   ddram_addr
);

  typedef enum logic [1:0] {
    S_8BIT,
    S_HI,
    S_LO
  } state_t;

  state_t      state, state_n;
  logic [1:0]  e_s, rs_s, rw_s;
  logic [3:0]  d_s1, d_s2;
  logic        e_q;
  logic        fall;
  logic [3:0]  hi_d;
  logic        hi_rs, hi_rw;
  logic [31:0] tcnt;
  logic        tmo;
  logic        inc_mode, ddram_sel;
  logic        exec, cmd4, hi_load;
  logic [7:0]  x_byte;
  logic        x_rs;

  // Illegal addresses behave as the end of their line.
  function automatic logic [6:0] step(
    input logic [6:0] a,
    input logic       inc
  );
    logic [6:0] r;
    if (inc) begin
      if (!a[6]) r = (a >= 7'h27) ? 7'h40 : a + 7'd1;
      else       r = (a >= 7'h67) ? 7'h00 : a + 7'd1;
    end else begin
      if (!a[6])
        r = (a == 7'h00 || a >= 7'h28) ? 7'h67 : a - 7'd1;
      else
        r = (a == 7'h40 || a >= 7'h68) ? 7'h27 : a - 7'd1;
    end
    return r;
  endfunction

  assign fall = e_q & ~e_s[1];
  assign tmo  = (NIBBLE_TIMEOUT != 0) && (tcnt == NIBBLE_TIMEOUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_s  <= '0;
      rs_s <= '0;
      rw_s <= '0;
      d_s1 <= '0;
      d_s2 <= '0;
      e_q  <= 1'b0;
    end else begin
      e_s  <= {e_s[0], LCD_E};
      rs_s <= {rs_s[0], LCD_RS};
      rw_s <= {rw_s[0], LCD_RW};
      d_s1 <= LCD_D;
      d_s2 <= d_s1;
      e_q  <= e_s[1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_8BIT;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    exec    = 1'b0;
    cmd4    = 1'b0;
    hi_load = 1'b0;
    x_byte  = {d_s2, 4'h0};
    x_rs    = 1'b0;
    unique case (state)
      S_8BIT: begin
        if (fall && !rw_s[1]) begin
          exec = 1'b1;
          if (!rs_s[1] && d_s2 == 4'h2)
            state_n = S_HI;
        end
      end
      S_HI: begin
        if (fall) begin
          hi_load = 1'b1;
          state_n = S_LO;
        end
      end
      S_LO: begin
        // A strobe colliding with the timeout starts a new byte.
        if (fall && tmo) begin
          hi_load = 1'b1;
        end else if (fall) begin
          state_n = S_HI;
          x_byte  = {hi_d, d_s2};
          x_rs    = hi_rs;
          exec    = !hi_rw;
          cmd4    = !hi_rw;
        end else if (tmo) begin
          state_n = S_HI;
        end
      end
      default: state_n = S_8BIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_d  <= '0;
      hi_rs <= 1'b0;
      hi_rw <= 1'b0;
      tcnt  <= '0;
    end else if (hi_load) begin
      hi_d  <= d_s2;
      hi_rs <= rs_s[1];
      hi_rw <= rw_s[1];
      tcnt  <= '0;
    end else if (state == S_LO) begin
      tcnt  <= tcnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_A      <= {16{8'h20}};
      row_B      <= {16{8'h20}};
      byte_valid <= 1'b0;
      byte_rs    <= 1'b0;
      byte_data  <= '0;
      mode_4bit  <= 1'b0;
      ddram_addr <= '0;
      inc_mode   <= 1'b1;
      ddram_sel  <= 1'b1;
    end else begin
      byte_valid <= exec;
      if (exec) begin
        byte_data <= x_byte;
        byte_rs   <= x_rs;
      end
      if (state == S_8BIT && state_n == S_HI)
        mode_4bit <= 1'b1;
      if (cmd4 && x_rs) begin
        if (ddram_sel) begin
          if (ddram_addr[6:4] == 3'b000)
            row_A[{ddram_addr[3:0], 3'b000} +: 8] <= x_byte;
          else if (ddram_addr[6:4] == 3'b100)
            row_B[{ddram_addr[3:0], 3'b000} +: 8] <= x_byte;
          ddram_addr <= step(ddram_addr, inc_mode);
        end
      end else if (cmd4) begin
        unique casez (x_byte)
          8'b1???????: begin
            ddram_sel  <= 1'b1;
            ddram_addr <= x_byte[6:0];
          end
          8'b01??????: ddram_sel <= 1'b0;
          8'b001?????: ;
          8'b0001????: begin
            if (!x_byte[3])
              ddram_addr <= step(ddram_addr, x_byte[2]);
          end
          8'b00001???: ;
          8'b000001??: inc_mode <= x_byte[1];
          8'b0000001?: ddram_addr <= '0;
          8'b00000001: begin
            row_A      <= {16{8'h20}};
            row_B      <= {16{8'h20}};
            ddram_addr <= '0;
            inc_mode   <= 1'b1;
            ddram_sel  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor.
// Drives HD44780 strobes and checks the shadow rows.
module tb_lcd_bus_monitor;

  localparam int unsigned TMO = 50;

  logic         clk;
  logic         reset_n;
  logic         LCD_E;
  logic         LCD_RS;
  logic         LCD_RW;
  logic [3:0]   LCD_D;
  logic [0:127] row_A;
  logic [0:127] row_B;
  logic         byte_valid;
  logic         byte_rs;
  logic [7:0]   byte_data;
  logic         mode_4bit;
  logic [6:0]   ddram_addr;

  int errors = 0;
  int checks = 0;
  int vcnt   = 0;
  int vbase;

  lcd_bus_monitor #(.NIBBLE_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .LCD_E      (LCD_E),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .LCD_D      (LCD_D),
    .row_A      (row_A),
    .row_B      (row_B),
    .byte_valid (byte_valid),
    .byte_rs    (byte_rs),
    .byte_data  (byte_data),
    .mode_4bit  (mode_4bit),
    .ddram_addr (ddram_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (byte_valid === 1'b1) vcnt <= vcnt + 1;

  task automatic check(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(
    input logic       rs,
    input logic       rw,
    input logic [3:0] d
  );
    @(negedge clk);
    LCD_RS = rs;
    LCD_RW = rw;
    LCD_D  = d;
    LCD_E  = 1'b1;
    repeat (4) @(negedge clk);
    LCD_E = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    strobe(rs, 1'b0, b[7:4]);
    strobe(rs, 1'b0, b[3:0]);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(1'b1, s[i]);
  endtask

  initial begin
    reset_n = 1'b0;
    LCD_E   = 1'b0;
    LCD_RS  = 1'b0;
    LCD_RW  = 1'b0;
    LCD_D   = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_rowA", row_A, {16{8'h20}});
    check("rst_rowB", row_B, {16{8'h20}});
    check("rst_valid", byte_valid, 0);
    check("rst_data", byte_data, 0);
    check("rst_rs", byte_rs, 0);
    check("rst_mode", mode_4bit, 0);
    check("rst_addr", ddram_addr, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    strobe(1'b0, 1'b0, 4'h3);
    strobe(1'b0, 1'b0, 4'h3);
    strobe(1'b0, 1'b0, 4'h3);
    strobe(1'b0, 1'b0, 4'h2);
    check("init_pulses", vcnt, 4);
    check("init_mode", mode_4bit, 1);
    check("init_data", byte_data, 8'h20);
    check("init_rowA", row_A, {16{8'h20}});

    send_byte(1'b0, 8'h80);
    send_str("PRESS BTN0");
    check("press_rowA", row_A, "PRESS BTN0      ");
    check("press_addr", ddram_addr, 7'h0A);
    check("press_rs", byte_rs, 1);
    check("press_data", byte_data, "0");
    check("press_pulses", vcnt, 15);

    send_byte(1'b0, 8'hC0);
    send_str("oooooooooooooooo");
    check("line2_addr", ddram_addr, 7'h50);
    send_str("X");
    check("line2_rowB", row_B, "oooooooooooooooo");
    check("line2_addrX", ddram_addr, 7'h51);
    check("line2_rowA", row_A, "PRESS BTN0      ");

    send_byte(1'b0, 8'h06);
    send_byte(1'b0, 8'hA7);
    check("set27_addr", ddram_addr, 7'h27);
    send_str("Z");
    check("wrap_inc", ddram_addr, 7'h40);
    send_byte(1'b0, 8'h04);
    send_str("Q");
    check("wrap_dec", ddram_addr, 7'h27);
    check("q_rowB", row_B, "Qooooooooooooooo");
    check("q_rowA", row_A, "PRESS BTN0      ");

    vbase = vcnt;
    strobe(1'b1, 1'b1, 4'h4);
    strobe(1'b1, 1'b1, 4'h1);
    check("read_pulses", vcnt - vbase, 0);
    check("read_addr", ddram_addr, 7'h27);

    vbase = vcnt;
    strobe(1'b0, 1'b0, 4'h4);
    repeat (TMO + 5) @(negedge clk);
    send_byte(1'b0, 8'h01);
    check("tmo_pulses", vcnt - vbase, 1);
    check("tmo_data", byte_data, 8'h01);
    check("tmo_rowA", row_A, {16{8'h20}});
    check("tmo_rowB", row_B, {16{8'h20}});
    check("tmo_addr", ddram_addr, 0);

    send_str("A");
    check("a_rowA", row_A, "A               ");
    check("a_addr", ddram_addr, 7'h01);

    strobe(1'b0, 1'b0, 4'h4);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rowA", row_A, {16{8'h20}});
    check("mid_mode", mode_4bit, 0);
    check("mid_addr", ddram_addr, 0);
    check("mid_data", byte_data, 0);
    check("mid_rs", byte_rs, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    vbase = vcnt;
    strobe(1'b0, 1'b0, 4'h1);
    check("post_pulses", vcnt - vbase, 1);
    check("post_data", byte_data, 8'h10);
    check("post_mode", mode_4bit, 0);
    check("post_rowA", row_A, {16{8'h20}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_bus_monitor.md
# lcd_bus_monitor

Passive receiver for the 4-bit HD44780-style LCD bus (`LCD_E`, `LCD_RS`, `LCD_RW`, `LCD_D`) driven by our LCD driver. It decodes nibble strobes into command and data bytes, executes the display-relevant commands, and maintains a shadow copy of the 16x2 visible DDRAM as `row_A`/`row_B`. It sits beside the LCD pins in simulation benches and on-chip debug, so game logic can be checked against what the panel actually received.

## Interface
- `NIBBLE_TIMEOUT`, default 1_000_000: clk cycles allowed between the high and low nibble before the phase resyncs to high; 0 disables the timeout.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `LCD_E`  in  1  enable strobe; data is captured on its falling edge.
- `LCD_RS`  in  1  1 = data, 0 = command.
- `LCD_RW`  in  1  1 = read cycle (no effect on state).
- `LCD_D`  in  4  nibble, upper nibble first.
- `row_A`  out  [0:127]  visible line 1, DDRAM 0x00–0x0F; char i at bits [8i +: 8].
- `row_B`  out  [0:127]  visible line 2, DDRAM 0x40–0x4F; same packing.
- `byte_valid`  out  1  one-cycle pulse per completed write byte.
- `byte_rs`  out  1  RS of the last byte.
- `byte_data`  out  8  last byte.
- `mode_4bit`  out  1  bus is in 4-bit mode.
- `ddram_addr`  out  7  current address counter.

## Operation
- Input synchronisation: all inputs pass through two flops; a falling edge is detected on the synchronised `LCD_E` (previous 1, current 0). `RS`/`RW`/`D` are taken from the same synchronised stage.
- States: `S_8BIT` (reset), `S_HI`, `S_LO`.
- `S_8BIT`: every strobe is one command byte {D, 0000}. For RW=0, RS=0, D=0x2, go to `S_HI` and set `mode_4bit`. D=0x3 and any other nibble are acknowledged with `byte_valid` and otherwise ignored.
- `S_HI`: latch the nibble, RS and RW, then go to `S_LO`.
- `S_LO`: form the byte {hi, D} and return to `S_HI`. RS/RW come from the high nibble.
- If RW=1, the transfer advances the phase but has no further effect and produces no `byte_valid`.
- Commands (RS=0):
  - 0x01 clear: all 32 chars become 0x20, addr=0, I/D=1, DDRAM select.
  - 0x02/0x03 home: addr=0.
  - 0x04–0x07 entry mode: latch I/D (bit 1). The shift bit is ignored.
  - 0x08–0x0F display control: ignored.
  - 0x10–0x1F: if S/C=0, move addr by R/L using the same wrap rules as data writes. If S/C=1, ignored.
  - 0x20–0x3F function set: ignored; stays in 4-bit.
  - 0x40–0x7F: select CGRAM; later data bytes are discarded and addr is unchanged.
  - 0x80–0xFF: select DDRAM, addr = byte[6:0].
- Data (RS=1, DDRAM selected): if addr is 0x00–0x0F, write `row_A[8*addr +: 8]`. If addr is 0x40–0x4F, write `row_B[8*(addr-0x40) +: 8]`. Other addresses are accepted but not stored. Then step addr by ±1 per I/D.
- Address wrap, increment: 0x27→0x40, 0x67→0x00. Decrement: 0x00→0x67, 0x40→0x27.
- Illegal addresses 0x28–0x3F and 0x68–0x7F set via 0x80 are stored in `ddram_addr`. Data writes there are discarded, and the next step treats them as the line end (increment→next line start, decrement→line start−1 using the same wrap rules).
- Timeout: in `S_LO`, a counter runs from the high-nibble capture. When it reaches `NIBBLE_TIMEOUT`, go to `S_HI` and drop the stored nibble.

## Timing
- Reset (async, `reset_n`=0):
  - `row_A` = `row_B` = 16×0x20.
  - `byte_valid`=0, `byte_rs`=0, `byte_data`=0.
  - `mode_4bit`=0, `ddram_addr`=0, I/D=1, DDRAM selected, state `S_8BIT`, sync flops low.
- Latency: outputs update on the 3rd rising `clk` edge after the first edge that samples `LCD_E` low: 2 sync stages plus 1 execute. `byte_valid` is high for exactly that one cycle.
- Every command, including clear, completes in that single cycle. There is no busy flag.
- Input requirements: `LCD_E` high ≥3 clk and low ≥3 clk. `RS`/`RW`/`D` stable ≥3 clk before and after the falling edge. Glitches shorter than 1 clk are not guaranteed to be rejected.
- Reset mid-byte discards the half-byte and returns to `S_8BIT`. The bus must be re-initialised.
- A strobe arriving in the same cycle as the timeout is treated as a new high nibble.

## Test plan
- Init: nibbles 0x3,0x3,0x3,0x2 (RS=0) → 4 `byte_valid` pulses, `mode_4bit`=1, rows all 0x20.
- After init, send 0x80 then "PRESS BTN0" as data → `row_A`="PRESS BTN0      ", `ddram_addr`=0x0A.
- Send 0xC0 then 16×"o", then "X" → `row_B`=16×"o", addr goes 0x4F→0x50, "X" not stored, `row_A` unchanged.
- Send 0x06 then set addr 0x27 and write "Z" → addr=0x40. Send 0x04 then write "Q" at 0x40 → `row_B[0:7]`="Q", addr=0x27.
- Send high nibble 0x4 only, wait `NIBBLE_TIMEOUT`+5 clk, then send byte 0x01 → rows cleared, addr=0, exactly one `byte_valid` (byte 0x01).
- Assert `reset_n`=0 between the two nibbles of 0x41 → outputs at reset values immediately, and state is `S_8BIT` after release.
